// File: rtl/jump_controller.sv
// Control-flow sequencer feeding the program counter: decodes jump class, owns the
// return-address stack, WAIT-style delays and the halt state, paced to a synchronous ROM.
module jump_controller #(
  parameter int ADDR_WIDTH    = 12,
  parameter int STACK_DEPTH   = 8,
  parameter int FETCH_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [2:0]            jump_op,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  zero_flag,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [2:0]            flagPC,
  output logic [ADDR_WIDTH-1:0] newAddress,
  output logic                  stack_error,
  output logic                  halted
);

  localparam int IDXW = $clog2(STACK_DEPTH);
  localparam int SPW  = IDXW + 1;

  localparam logic [2:0] PC_HOLD     = 3'd0;
  localparam logic [2:0] PC_INCREASE = 3'd1;
  localparam logic [2:0] PC_JUMP     = 3'd2;
  localparam logic [2:0] PC_DELAY    = 3'd3;

  localparam logic [3:0]     LATENCY = 4'(FETCH_LATENCY);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_FETCH_WAIT,
    S_DELAYING,
    S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JMP  = 3'd1,
    OP_BEQZ = 3'd2,
    OP_BNEZ = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_WAIT = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [SPW-1:0]          sp_q;
  logic [ADDR_WIDTH-1:0]   wait_addr_q, wait_addr_d;
  logic [2:0]              flag_d;
  logic [ADDR_WIDTH-1:0]   new_addr_d;
  logic                    err_d;
  logic                    push, pop;

  logic [ADDR_WIDTH-1:0]   stack_mem [STACK_DEPTH];
  logic [IDXW-1:0]         push_idx, top_idx;
  logic [ADDR_WIDTH-1:0]   return_addr;

  // With sp == STACK_DEPTH the low bits wrap to 0, so top_idx still names the last entry.
  assign push_idx    = sp_q[IDXW-1:0];
  assign top_idx     = sp_q[IDXW-1:0] - IDXW'(1);
  assign return_addr = address + ADDR_WIDTH'(1);
  assign halted      = (state_q == S_HALTED);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_addr_d = wait_addr_q;
    flag_d      = PC_HOLD;
    new_addr_d  = newAddress;
    err_d       = stack_error;
    push        = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (instr_valid) begin
          state_d = S_FETCH_WAIT;
          cnt_d   = LATENCY;
          case (op_e'(jump_op))
            OP_NONE: flag_d = PC_INCREASE;
            OP_JMP: begin
              flag_d     = PC_JUMP;
              new_addr_d = target;
            end
            OP_BEQZ: begin
              flag_d = zero_flag ? PC_JUMP : PC_INCREASE;
              if (zero_flag) new_addr_d = target;
            end
            OP_BNEZ: begin
              flag_d = !zero_flag ? PC_JUMP : PC_INCREASE;
              if (!zero_flag) new_addr_d = target;
            end
            OP_CALL: begin
              if (sp_q == SP_FULL) begin
                err_d   = 1'b1;
                state_d = S_HALTED;
              end else begin
                push       = 1'b1;
                flag_d     = PC_JUMP;
                new_addr_d = target;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                err_d   = 1'b1;
                state_d = S_HALTED;
              end else begin
                pop        = 1'b1;
                flag_d     = PC_JUMP;
                new_addr_d = stack_mem[top_idx];
              end
            end
            OP_WAIT: begin
              flag_d      = PC_DELAY;
              wait_addr_d = address;
              state_d     = S_DELAYING;
            end
            OP_HALT: state_d = S_HALTED;
          endcase
        end
      end

      // The ROM needs FETCH_LATENCY cycles to present the instruction at the new PC.
      S_FETCH_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DELAYING: begin
        if (address == wait_addr_q) begin
          flag_d = PC_DELAY;
        end else begin
          state_d = S_FETCH_WAIT;
          cnt_d   = LATENCY;
        end
      end

      S_HALTED: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH_WAIT;
      cnt_q       <= LATENCY;
      sp_q        <= '0;
      wait_addr_q <= '0;
      flagPC      <= PC_HOLD;
      newAddress  <= '0;
      stack_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_addr_q <= wait_addr_d;
      flagPC      <= flag_d;
      newAddress  <= new_addr_d;
      stack_error <= err_d;
      if (push)     sp_q <= sp_q + SPW'(1);
      else if (pop) sp_q <= sp_q - SPW'(1);
    end
  end

  // NOTE: the stack array has no reset; only sp is cleared, which is enough to empty it.
  always_ff @(posedge clock) begin
    if (push && !reset) stack_mem[push_idx] <= return_addr;
  end

endmodule
